// File: rtl/ilkn_pkg.sv
// Shared Interlaken lane constants: descrambler FSM states, LFSR taps and block headers.
package ilkn_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } desc_state_t;

    localparam int LFSR_W = 58;
    localparam int TAP_A  = 38;
    localparam int TAP_B  = 57;

    localparam logic [1:0] HDR_CTRL = 2'b10;
    localparam logic [1:0] HDR_DATA = 2'b01;

endpackage

// File: rtl/ilkn_lfsr_step.sv
// 64-bit parallel x^58+x^39+1 self-synchronous descramble step, LSB first.
// Purely combinational; no latency and no flow control.
module ilkn_lfsr_step
    import ilkn_pkg::*;
(
    input  logic [LFSR_W-1:0] state,
    input  logic [63:0]       data,
    output logic [LFSR_W-1:0] next_state,
    output logic [63:0]       data_out
);

    logic [LFSR_W-1:0] s;

    // The received (scrambled) bit is what shifts in, so TX and RX stay in step.
    always_comb begin
        s        = state;
        data_out = '0;
        for (int i = 0; i < 64; i++) begin
            data_out[i] = data[i] ^ s[TAP_A] ^ s[TAP_B];
            s           = {s[LFSR_W-2:0], data[i]};
        end
        next_state = s;
    end

endmodule

// File: rtl/metaframe_descrambler.sv
// Per-lane metaframe delineation, LFSR seeding and payload descrambling.
// 1-cycle latency for every valid word; no backpressure, invalid cycles hold all state.
module metaframe_descrambler
    import ilkn_pkg::*;
#(
    parameter int          DATA_WIDTH       = 64,
    parameter logic [63:0] SYNC_WORD        = 64'h78f678f678f678f6,
    parameter int          META_FRAME_LEN   = 2048,
    parameter int          GOOD_SYNC_THRESH = 4,
    parameter int          BAD_SYNC_THRESH  = 4,
    parameter int          SCRAM_ERR_THRESH = 3
) (
    input  logic                  USER_CLK,
    input  logic                  SYSTEM_RESET_N,
    input  logic                  PASSTHROUGH,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic [1:0]            HEADER_IN,
    input  logic                  DATA_IN_VALID,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic [1:0]            HEADER_OUT,
    output logic                  DATA_OUT_VALID,
    output logic                  META_WORD_OUT,
    output logic                  LOCKED,
    output logic                  SYNC_ERR,
    output logic                  SCRAM_ERR,
    output logic [15:0]           LOCK_LOSS_CNT
);

    localparam int              POS_W    = $clog2(META_FRAME_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(META_FRAME_LEN - 1);
    localparam logic [3:0]      GOOD_T   = 4'(GOOD_SYNC_THRESH);
    localparam logic [3:0]      BAD_T    = 4'(BAD_SYNC_THRESH);
    localparam logic [3:0]      SCRAM_T  = 4'(SCRAM_ERR_THRESH);

    desc_state_t       state;
    logic [POS_W-1:0]  pos;
    logic [POS_W-1:0]  pos_next;
    logic [3:0]        good;
    logic [3:0]        bad;
    logic [3:0]        mis;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [63:0]       desc;
    logic              sync_ok;
    logic              seed_ok;

    assign sync_ok  = (HEADER_IN == HDR_CTRL) && (DATA_IN == SYNC_WORD);
    assign seed_ok  = (HEADER_IN == HDR_CTRL) && (DATA_IN[LFSR_W-1:0] == lfsr);
    assign pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
    assign LOCKED   = (state == ST_LOCKED);

    ilkn_lfsr_step u_step (
        .state      (lfsr),
        .data       (DATA_IN),
        .next_state (lfsr_next),
        .data_out   (desc)
    );

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state          <= ST_HUNT;
            pos            <= '0;
            good           <= '0;
            bad            <= '0;
            mis            <= '0;
            lfsr           <= '1;
            DATA_OUT       <= '0;
            HEADER_OUT     <= '0;
            DATA_OUT_VALID <= 1'b0;
            META_WORD_OUT  <= 1'b0;
            SYNC_ERR       <= 1'b0;
            SCRAM_ERR      <= 1'b0;
            LOCK_LOSS_CNT  <= '0;
        end else begin
            DATA_OUT_VALID <= 1'b0;
            META_WORD_OUT  <= 1'b0;
            SYNC_ERR       <= 1'b0;
            SCRAM_ERR      <= 1'b0;
            if (PASSTHROUGH) begin
                // Bypass drops any lock silently; it is not a lock loss.
                state          <= ST_HUNT;
                pos            <= '0;
                good           <= '0;
                bad            <= '0;
                mis            <= '0;
                DATA_OUT_VALID <= DATA_IN_VALID;
                if (DATA_IN_VALID) begin
                    DATA_OUT   <= DATA_IN;
                    HEADER_OUT <= HEADER_IN;
                end
            end else if (DATA_IN_VALID) begin
                DATA_OUT   <= DATA_IN;
                HEADER_OUT <= HEADER_IN;
                pos        <= pos_next;
                case (state)
                    ST_HUNT: begin
                        pos <= '0;
                        if (sync_ok) begin
                            pos   <= POS_W'(1);
                            good  <= 4'd1;
                            state <= ST_VERIFY;
                        end
                    end
                    ST_VERIFY: begin
                        if (pos == '0) begin
                            if (sync_ok) begin
                                good <= good + 4'd1;
                            end else begin
                                state <= ST_HUNT;
                                pos   <= '0;
                                good  <= '0;
                            end
                        end else if (pos == POS_W'(1) && good == GOOD_T) begin
                            lfsr  <= DATA_IN[LFSR_W-1:0];
                            bad   <= '0;
                            mis   <= '0;
                            state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        DATA_OUT_VALID <= 1'b1;
                        if (pos == '0) begin
                            META_WORD_OUT <= 1'b1;
                            if (sync_ok) begin
                                bad <= '0;
                            end else begin
                                SYNC_ERR <= 1'b1;
                                if (bad + 4'd1 == BAD_T) begin
                                    state <= ST_HUNT;
                                    pos   <= '0;
                                    good  <= '0;
                                    bad   <= '0;
                                    mis   <= '0;
                                    if (LOCK_LOSS_CNT != 16'hFFFF)
                                        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 16'd1;
                                end else begin
                                    bad <= bad + 4'd1;
                                end
                            end
                        end else if (pos == POS_W'(1)) begin
                            META_WORD_OUT <= 1'b1;
                            if (seed_ok) begin
                                mis <= '0;
                            end else begin
                                // Trust the transmitted state so payload recovers immediately.
                                SCRAM_ERR <= 1'b1;
                                lfsr      <= DATA_IN[LFSR_W-1:0];
                                if (mis + 4'd1 == SCRAM_T) begin
                                    state <= ST_HUNT;
                                    pos   <= '0;
                                    good  <= '0;
                                    bad   <= '0;
                                    mis   <= '0;
                                    if (LOCK_LOSS_CNT != 16'hFFFF)
                                        LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 16'd1;
                                end else begin
                                    mis <= mis + 4'd1;
                                end
                            end
                        end else begin
                            DATA_OUT <= desc;
                            lfsr     <= lfsr_next;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_metaframe_descrambler.sv
// Directed bench: a word table built from a TX scrambler model, plus a hand-written async reset sequence.
module tb_metaframe_descrambler;
    import ilkn_pkg::*;

    localparam logic [63:0] SYNC = 64'h78f678f678f678f6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pt = 1'b0;
    logic [63:0] din = '0;
    logic [1:0]  hdr = '0;
    logic        vld = 1'b0;
    logic [63:0] dout;
    logic [1:0]  hout;
    logic        ovld, meta, locked, serr, cerr;
    logic [15:0] llc;

    metaframe_descrambler #(
        .DATA_WIDTH       (64),
        .SYNC_WORD        (SYNC),
        .META_FRAME_LEN   (8),
        .GOOD_SYNC_THRESH (4),
        .BAD_SYNC_THRESH  (4),
        .SCRAM_ERR_THRESH (3)
    ) dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .PASSTHROUGH    (pt),
        .DATA_IN        (din),
        .HEADER_IN      (hdr),
        .DATA_IN_VALID  (vld),
        .DATA_OUT       (dout),
        .HEADER_OUT     (hout),
        .DATA_OUT_VALID (ovld),
        .META_WORD_OUT  (meta),
        .LOCKED         (locked),
        .SYNC_ERR       (serr),
        .SCRAM_ERR      (cerr),
        .LOCK_LOSS_CNT  (llc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          vld;
        bit          pt;
        logic [1:0]  hdr;
        logic [63:0] dat;
        bit          e_vld;
        logic [63:0] e_dat;
        bit          e_meta;
        bit          e_lk;
        bit          e_se;
        bit          e_ce;
        logic [15:0] e_llc;
    } vec_t;

    vec_t        tbl[$];
    logic [57:0] tx_s;
    logic [31:0] pcnt = 32'd0;
    logic [15:0] cur_llc = 16'd0;
    bit          cur_lk = 1'b0;
    int          n_total = 0;
    int          n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endfunction

    // TX-side scrambler: the scrambled bit feeds the shift register.
    function automatic logic [63:0] scramble(logic [63:0] p);
        logic [63:0] c;
        for (int i = 0; i < 64; i++) begin
            c[i] = p[i] ^ tx_s[38] ^ tx_s[57];
            tx_s = {tx_s[56:0], c[i]};
        end
        return c;
    endfunction

    function automatic void push(bit v, bit p, logic [1:0] h, logic [63:0] d, bit ev,
                                 logic [63:0] ed, bit em, bit el, bit es, bit ec);
        vec_t r;
        r.vld = v; r.pt = p; r.hdr = h; r.dat = d;
        r.e_vld = ev; r.e_dat = ed; r.e_meta = em; r.e_lk = el;
        r.e_se = es; r.e_ce = ec; r.e_llc = cur_llc;
        tbl.push_back(r);
    endfunction

    function automatic void maybe_gap(bit en, bit lk);
        if (en && $urandom_range(0, 1) == 1)
            push(0, 0, HDR_DATA, {$urandom(), $urandom()}, 0, 64'h0, 0, lk, 0, 0);
    endfunction

    // One metaframe; lk1/lk2 = expected lock after the sync word / after the state word.
    function automatic void add_mf(bit sbad, bit cbad, bit lk1, bit lk2, bit gaps);
        logic [63:0] w, p;
        bit          lk0;
        lk0 = cur_lk;
        maybe_gap(gaps, lk0);
        w = sbad ? (SYNC ^ 64'h1) : SYNC;
        if (lk0 && !lk1) cur_llc++;
        push(1, 0, HDR_CTRL, w, lk0, w, lk0, lk1, lk0 && sbad, 0);
        maybe_gap(gaps, lk1);
        if (cbad) tx_s = tx_s ^ 58'h15A5A5A5A5A5A5A;
        w = {6'h15, tx_s};
        if (lk1 && !lk2) cur_llc++;
        push(1, 0, HDR_CTRL, w, lk1, w, lk1, lk2, 0, lk1 && cbad);
        for (int k = 2; k < 8; k++) begin
            maybe_gap(gaps, lk2);
            pcnt++;
            p = {pcnt * 32'h9E3779B9, ~pcnt};
            w = scramble(p);
            push(1, 0, HDR_DATA, w, lk2, p, 0, lk2, 0, 0);
        end
        cur_lk = lk2;
    endfunction

    function automatic void acquire();
        for (int k = 0; k < 3; k++) add_mf(0, 0, 0, 0, 0);
        add_mf(0, 0, 0, 1, 0);
    endfunction

    task automatic drive(input vec_t r);
        pt  = r.pt;
        vld = r.vld;
        hdr = r.hdr;
        din = r.dat;
    endtask

    function automatic void compare(vec_t r, int idx);
        check($sformatf("w%0d_valid", idx), 64'(ovld), 64'(r.e_vld));
        check($sformatf("w%0d_meta", idx), 64'(meta), 64'(r.e_meta));
        check($sformatf("w%0d_locked", idx), 64'(locked), 64'(r.e_lk));
        check($sformatf("w%0d_sync_err", idx), 64'(serr), 64'(r.e_se));
        check($sformatf("w%0d_scram_err", idx), 64'(cerr), 64'(r.e_ce));
        check($sformatf("w%0d_llc", idx), 64'(llc), 64'(r.e_llc));
        if (r.e_vld) begin
            check($sformatf("w%0d_data", idx), dout, r.e_dat);
            check($sformatf("w%0d_hdr", idx), 64'(hout), 64'(r.hdr));
        end
    endfunction

    initial begin
        vec_t idle;
        idle = '{vld: 0, pt: 0, hdr: 2'b00, dat: 64'h0, e_vld: 0, e_dat: 64'h0,
                 e_meta: 0, e_lk: 0, e_se: 0, e_ce: 0, e_llc: 16'h0};

        // Scenario 1: noise, acquire from seed, one locked metaframe.
        tx_s = 58'h0123456789ABCDE;
        for (int k = 0; k < 3; k++)
            push(1, 0, HDR_DATA, {$urandom(), $urandom()}, 0, 64'h0, 0, 0, 0, 0);
        acquire();
        add_mf(0, 0, 1, 1, 0);
        // Scenario 2: 3 bad syncs, 1 good, 4 bad -> exit on the 4th.
        for (int k = 0; k < 3; k++) add_mf(1, 0, 1, 1, 0);
        add_mf(0, 0, 1, 1, 0);
        for (int k = 0; k < 3; k++) add_mf(1, 0, 1, 1, 0);
        add_mf(1, 0, 0, 0, 0);
        acquire();
        // Scenario 3: state-word mismatches with TX reseeds.
        for (int k = 0; k < 2; k++) add_mf(0, 1, 1, 1, 0);
        add_mf(0, 0, 1, 1, 0);
        for (int k = 0; k < 2; k++) add_mf(0, 1, 1, 1, 0);
        add_mf(0, 1, 1, 0, 0);
        acquire();
        // Scenario 4: locked with random valid gaps.
        add_mf(0, 0, 1, 1, 1);
        add_mf(0, 0, 1, 1, 1);
        // Scenario 5: passthrough for 10 words, then a VERIFY abort and re-acquire.
        for (int k = 0; k < 10; k++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            push(k != 4, 1, HDR_DATA, r, k != 4, r, 0, 0, 0, 0);
        end
        cur_lk = 0;
        add_mf(0, 0, 0, 0, 0);
        add_mf(0, 0, 0, 0, 0);
        add_mf(1, 0, 0, 0, 0);
        acquire();
        add_mf(0, 0, 1, 1, 0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {dout[47:0], hout, ovld, meta, locked, serr, cerr, 9'b0} | 64'(llc), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i <= tbl.size(); i++) begin
            @(negedge clk);
            if (i > 0) compare(tbl[i-1], i - 1);
            if (i < tbl.size()) drive(tbl[i]);
            else drive(idle);
        end

        // Scenario 6: async reset pulse between edges while locked.
        #1;
        check("pre_reset_locked", 64'(locked), 64'h1);
        check("pre_reset_llc", 64'(llc), 64'd2);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {dout[47:0], hout, ovld, meta, locked, serr, cerr, 9'b0}, 64'h0);
        check("async_reset_dout_hi", 64'(dout[63:48]), 64'h0);
        check("async_reset_llc", 64'(llc), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_locked", 64'(locked), 64'h0);
        check("post_reset_llc", 64'(llc), 64'h0);
        check("post_reset_valid", 64'(ovld), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
